// File: rtl/out_arbiter_pkg.sv
// Shared switch definitions: flit type encoding, type-field geometry and arbiter FSM states.
package out_arbiter_pkg;

    localparam int unsigned DEF_BUS_SIZE = 32;
    localparam int unsigned DEF_PORTS    = 5;
    localparam int unsigned DEF_IDX_W    = 3;
    localparam int unsigned TYPE_W       = 2;

    localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
    localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b01;
    localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b10;
    localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Increment a port index, wrapping to zero at the port count.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/out_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above start, wrapping past N-1 back to 0.
module rr_picker #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] rot;
    int unsigned  off;
    int unsigned  sum;

    // Rotating the doubled vector puts the start position at bit 0.
    assign rot = N'({req, req} >> start);

    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = 32'(k);
            end
        end
        sum = 32'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = IDX_W'(sum);
    end

endmodule

// File: rtl/out_arbiter.sv
// Output stage: round-robin wormhole arbitration over the input queues into a registered output link.
module out_arbiter
    import out_arbiter_pkg::*;
#(
    parameter int unsigned BUS_SIZE = DEF_BUS_SIZE,
    parameter int unsigned PORTS    = DEF_PORTS,
    parameter int unsigned IDX_W    = DEF_IDX_W
) (
    input  logic                      clk,
    input  logic                      a_rst,
    input  logic [PORTS-1:0]          q_empty,
    input  logic [PORTS*BUS_SIZE-1:0] q_data,
    output logic [PORTS-1:0]          q_readed,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [BUS_SIZE-1:0]       out_data,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      drop
);

    localparam int unsigned TYPE_HI = BUS_SIZE - 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 valid_q, valid_d;
    logic [BUS_SIZE-1:0]  data_q, data_d;
    logic                 drop_q, drop_d;

    logic [TYPE_W-1:0]    head_type [PORTS];
    logic [PORTS-1:0]     cand;
    logic [PORTS-1:0]     stray;
    logic                 stray_found;
    logic [IDX_W-1:0]     stray_idx;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [BUS_SIZE-1:0]  pick_flit;
    logic [BUS_SIZE-1:0]  own_flit;
    logic                 load;
    logic                 pop_en;
    logic [IDX_W-1:0]     pop_idx;
    logic                 do_load;

    // Classify every queue head as a packet start (HEAD/SINGLE) or a stray body/tail.
    always_comb begin
        stray_found = 1'b0;
        stray_idx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            head_type[i] = q_data[i*BUS_SIZE + BUS_SIZE - TYPE_W +: TYPE_W];
            cand[i]  = ~q_empty[i] & ((head_type[i] == FLIT_HEAD) | (head_type[i] == FLIT_SINGLE));
            stray[i] = ~q_empty[i] & ~cand[i];
        end
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (stray[i]) begin
                stray_found = 1'b1;
                stray_idx   = IDX_W'(i);
            end
        end
    end

    rr_picker #(
        .N     (PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (cand),
        .start (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_flit = q_data[32'(pick_idx)*BUS_SIZE +: BUS_SIZE];
    assign own_flit  = q_data[32'(owner_q)*BUS_SIZE +: BUS_SIZE];
    assign load      = ~valid_q | out_ready;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        pop_en  = 1'b0;
        pop_idx = '0;
        do_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load && pick_found) begin
                    pop_en  = 1'b1;
                    pop_idx = pick_idx;
                    do_load = 1'b1;
                    data_d  = pick_flit;
                    owner_d = pick_idx;
                    if (pick_flit[TYPE_HI -: TYPE_W] == FLIT_HEAD) begin
                        state_d = ST_LOCKED;
                    end else begin
                        rr_d = IDX_W'(wrap_inc(32'(pick_idx), PORTS));
                    end
                end else if (load && stray_found) begin
                    pop_en  = 1'b1;
                    pop_idx = stray_idx;
                    drop_d  = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Wormhole: only the owner may advance; an empty owner stalls the link.
                if (load && !q_empty[owner_q]) begin
                    pop_en  = 1'b1;
                    pop_idx = owner_q;
                    do_load = 1'b1;
                    data_d  = own_flit;
                    if ((own_flit[TYPE_HI -: TYPE_W] == FLIT_TAIL) ||
                        (own_flit[TYPE_HI -: TYPE_W] == FLIT_SINGLE)) begin
                        state_d = ST_IDLE;
                        rr_d    = IDX_W'(wrap_inc(32'(owner_q), PORTS));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign q_readed  = (pop_en && !a_rst) ? (PORTS'(1) << pop_idx) : '0;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q == ST_LOCKED);
    assign owner     = owner_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_out_arbiter.sv
// Bench for out_arbiter: reset-state vector table, directed packet sequences and random traffic against a queue model.
module tb_out_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned NP = 5;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic             clk = 1'b0;
    logic             a_rst;
    logic [NP-1:0]    q_empty;
    logic [NP*BW-1:0] q_data;
    logic [NP-1:0]    q_readed;
    logic             out_ready;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             busy;
    logic [2:0]       owner;
    logic             drop;

    always #5 clk = ~clk;

    out_arbiter dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_readed  (q_readed),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .owner     (owner),
        .drop      (drop)
    );

    int errors = 0;
    int checks = 0;

    // Bench-side queues and a spec-level model of the output stage.
    logic [BW-1:0] fifo [NP][$];
    bit            m_locked;
    int            m_rr;
    int            m_owner;
    bit            m_valid;
    logic [BW-1:0] m_data;
    bit            m_drop;
    logic [NP-1:0] obs_pops [$];
    int            tag = 1;

    typedef struct {
        logic [NP-1:0]   empty;
        logic [2*NP-1:0] typ;
        logic [NP-1:0]   exp_rd;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [1:0] t);
        logic [BW-1:0] f;
        f = {t, 30'(tag)};
        tag++;
        return f;
    endfunction

    function automatic bit is_start(input logic [BW-1:0] f);
        return (f[BW-1:BW-2] == T_HEAD) || (f[BW-1:BW-2] == T_SINGLE);
    endfunction

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            q_empty[i] = (fifo[i].size() == 0);
            q_data[i*BW +: BW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_rr     = 0;
        m_owner  = 0;
        m_valid  = 0;
        m_data   = '0;
        m_drop   = 0;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NP; i++) fifo[i].delete();
    endtask

    task automatic push_pkt(input int q, input int nbody);
        if (nbody < 0) begin
            fifo[q].push_back(mk(T_SINGLE));
        end else begin
            fifo[q].push_back(mk(T_HEAD));
            for (int b = 0; b < nbody; b++) fifo[q].push_back(mk(T_BODY));
            fifo[q].push_back(mk(T_TAIL));
        end
    endtask

    // One clock: drive at the negedge, check the pop, advance the model, check registers at the next negedge.
    task automatic step(input bit rdy);
        int            pop;
        bit            disc;
        bit            ld;
        logic [BW-1:0] f;
        logic [1:0]    t;
        out_ready = rdy;
        drive();
        #1;
        ld   = !m_valid || rdy;
        pop  = -1;
        disc = 0;
        if (ld) begin
            if (!m_locked) begin
                for (int k = 0; k < NP; k++) begin
                    int i;
                    i = (m_rr + k) % NP;
                    if (pop < 0 && fifo[i].size() != 0 && is_start(fifo[i][0])) pop = i;
                end
                if (pop < 0) begin
                    for (int i = 0; i < NP; i++) begin
                        if (pop < 0 && fifo[i].size() != 0) begin
                            pop  = i;
                            disc = 1;
                        end
                    end
                end
            end else if (fifo[m_owner].size() != 0) begin
                pop = m_owner;
            end
        end
        chk("q_readed", BW'(q_readed), (pop < 0) ? '0 : (BW'(1) << pop));
        if (q_readed != '0) obs_pops.push_back(q_readed);
        @(posedge clk);
        m_drop = disc;
        if (pop >= 0) begin
            f = fifo[pop].pop_front();
            if (disc) begin
                if (rdy) m_valid = 0;
            end else begin
                m_valid = 1;
                m_data  = f;
                t       = f[BW-1:BW-2];
                if (!m_locked) begin
                    m_owner = pop;
                    if (t == T_HEAD) m_locked = 1;
                    else m_rr = (pop + 1) % NP;
                end else if (t == T_TAIL || t == T_SINGLE) begin
                    m_locked = 0;
                    m_rr     = (m_owner + 1) % NP;
                end
            end
        end else if (rdy) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("out_valid", BW'(out_valid), BW'(m_valid));
        chk("busy", BW'(busy), BW'(m_locked));
        chk("owner", BW'(owner), BW'(m_owner));
        chk("drop", BW'(drop), BW'(m_drop));
        if (m_valid) chk("out_data", out_data, m_data);
    endtask

    // Called at a negedge; holds reset for one full cycle with the queues still presented.
    task automatic do_reset();
        a_rst = 1'b1;
        drive();
        #1;
        chk("rst_q_readed", BW'(q_readed), '0);
        chk("rst_out_valid", BW'(out_valid), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_owner", BW'(owner), '0);
        chk("rst_drop", BW'(drop), '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_q_readed", BW'(q_readed), '0);
        chk("rst_out_data", out_data, '0);
        a_rst = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] order_exp [6];
        a_rst     = 1'b1;
        out_ready = 1'b0;
        q_empty   = '1;
        q_data    = '0;
        model_reset();

        vecs[0] = '{5'b11111, 10'b00_00_00_00_00, 5'b00000};
        vecs[1] = '{5'b11011, 10'b00_00_11_00_00, 5'b00100};
        vecs[2] = '{5'b00000, 10'b01_01_01_01_01, 5'b00001};
        vecs[3] = '{5'b10101, 10'b00_10_00_00_00, 5'b00010};
        vecs[4] = '{5'b01101, 10'b01_00_00_00_00, 5'b10000};
        vecs[5] = '{5'b11010, 10'b00_00_00_00_10, 5'b00001};
        vecs[6] = '{5'b10101, 10'b00_11_00_01_00, 5'b00010};
        vecs[7] = '{5'b11111, 10'b01_01_01_01_01, 5'b00000};
        vecs[8] = '{5'b01111, 10'b11_01_01_01_01, 5'b10000};

        @(negedge clk);
        do_reset();

        // Combinational pop choice straight out of reset (rr pointer at 0, output empty).
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            a_rst = 1'b1;
            #1;
            a_rst     = 1'b0;
            out_ready = 1'b1;
            q_empty   = vecs[v].empty;
            for (int i = 0; i < NP; i++) q_data[i*BW +: BW] = {vecs[v].typ[2*i +: 2], 30'(i)};
            #1;
            chk($sformatf("vec%0d_q_readed", v), BW'(q_readed), BW'(vecs[v].exp_rd));
        end
        @(negedge clk);
        clear_fifos();
        do_reset();

        // SINGLE in queue 2, then verify the pointer moved to 3.
        fifo[2].push_back(32'hC000_00AA);
        step(1);
        chk("single_out_data", out_data, 32'hC000_00AA);
        fifo[1].push_back(mk(T_SINGLE));
        fifo[3].push_back(mk(T_SINGLE));
        obs_pops.delete();
        step(1);
        step(1);
        step(1);
        chk("rr_after_single_first", BW'(obs_pops[0]), BW'(5'b01000));
        chk("rr_after_single_second", BW'(obs_pops[1]), BW'(5'b00010));

        // Packet on queue 0 then a SINGLE on queue 1.
        clear_fifos();
        do_reset();
        push_pkt(0, 1);
        fifo[1].push_back(mk(T_SINGLE));
        for (int c = 0; c < 6; c++) step(1);
        chk("pkt_then_single_owner", BW'(owner), 32'd1);

        // Continuous SINGLEs in every queue: strict rotation.
        clear_fifos();
        do_reset();
        for (int i = 0; i < NP; i++) begin
            push_pkt(i, -1);
            push_pkt(i, -1);
        end
        obs_pops.delete();
        for (int c = 0; c < 8; c++) step(1);
        order_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), BW'(obs_pops[k]), BW'(order_exp[k]));

        // Locked on queue 3 with downstream back-pressure.
        clear_fifos();
        do_reset();
        push_pkt(3, 3);
        fifo[1].push_back(mk(T_SINGLE));
        step(1);
        step(1);
        for (int c = 0; c < 4; c++) begin
            step(0);
            chk("stall_owner", BW'(owner), 32'd3);
            chk("stall_busy", BW'(busy), 32'd1);
        end
        for (int c = 0; c < 6; c++) step(1);

        // Stray BODY with no heads anywhere is discarded.
        clear_fifos();
        do_reset();
        fifo[1].push_back(mk(T_BODY));
        step(1);
        chk("discard_drop", BW'(drop), 32'd1);
        chk("discard_valid", BW'(out_valid), 32'd0);
        step(1);
        chk("discard_drop_clear", BW'(drop), 32'd0);

        // Reset in the middle of a 4-flit packet, remaining flits stay queued.
        clear_fifos();
        do_reset();
        push_pkt(4, 2);
        step(1);
        step(1);
        do_reset();
        fifo[0].push_back(mk(T_SINGLE));
        for (int c = 0; c < 5; c++) step(1);

        // Random packet traffic with random back-pressure.
        clear_fifos();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (fifo[i].size() < 6 && $urandom_range(0, 9) < 2) begin
                    if ($urandom_range(0, 19) == 0) fifo[i].push_back(mk(T_BODY));
                    else if ($urandom_range(0, 2) == 0) push_pkt(i, -1);
                    else push_pkt(i, int'($urandom_range(0, 3)));
                end
            end
            step($urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
